rptr_ctrl: RTL and testbench

RPTR_CTRL -- requirements
Module: rptr_ctrl

---
 rtl/fifo_ptr_pkg.sv | 27 ++
 rtl/gray2bin.sv | 17 +
 rtl/rptr_ctrl.sv | 91 +++++++++
 tb/tb_rptr_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async-FIFO read and write pointer controllers.
// The functions work on a wide word; narrower pointers are zero-extended on entry.
package fifo_ptr_pkg;

    localparam int PTR_WORD_W = 32;

    typedef logic [PTR_WORD_W-1:0] ptr_word_t;

    // Pointers carry one extra wrap bit beyond the RAM address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_WORD_W-1] = gray[PTR_WORD_W-1];
        for (int i = PTR_WORD_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterised Gray-to-binary converter (prefix XOR from the MSB down).
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        // NOTE: every bit is assigned on every pass, so no latch can be inferred.
        bin_o[W-1] = gray_i[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/rptr_ctrl.sv
// Async-FIFO read-pointer controller: Gray/binary read pointer, empty/almost-empty flags, level.
// Build option: define RPTR_UNDERFLOW_DET_EN to add the sticky read-while-empty detector.
module rptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                r_en,
    input  logic [ADDR_W:0]     g_wptr_sync,
    output logic                r_fire,
    output logic [ADDR_W-1:0]   raddr,
    output logic [ADDR_W:0]     g_rptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDR_W:0]     rlevel,
    output logic                underflow
);

    localparam int PTR_W = ptr_width(ADDR_W);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0] b_rptr_q, b_rptr_d;
    logic [PTR_W-1:0] g_rptr_q, g_rptr_d;
    logic [PTR_W-1:0] rlevel_q, rlevel_d;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic [PTR_W-1:0] wptr_bin;

    gray2bin #(
        .W (PTR_W)
    ) u_wptr_g2b (
        .gray_i (g_wptr_sync),
        .bin_o  (wptr_bin)
    );

    // A read while empty is never accepted, so the pointers cannot overtake the writer.
    assign r_fire = r_en & ~empty_q;

    // Flags and level look at the post-read pointer and the current write pointer together,
    // so a write landing in the same cycle as a read is accounted for immediately.
    always_comb begin
        b_rptr_d = b_rptr_q + {{(PTR_W-1){1'b0}}, r_fire};
        g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
        rlevel_d = wptr_bin - b_rptr_d;
        empty_d  = (g_rptr_d == g_wptr_sync);
        aempty_d = (rlevel_d <= AEMPTY_LVL);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            rlevel_q <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            rlevel_q <= rlevel_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
        end
    end

    assign raddr        = b_rptr_q[ADDR_W-1:0];
    assign g_rptr       = g_rptr_q;
    assign rlevel       = rlevel_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;

`ifdef RPTR_UNDERFLOW_DET_EN
    logic underflow_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow_q <= 1'b0;
        end else if (r_en & empty_q) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_ctrl.sv
// Directed, scoreboard-based bench for rptr_ctrl with ADDR_W=3, AEMPTY_TH=1.
module tb_rptr_ctrl;

    localparam int ADDR_W    = 3;
    localparam int AEMPTY_TH = 1;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       r_en = 1'b0;
    logic [3:0] g_wptr_sync = 4'd0;
    logic       r_fire;
    logic [2:0] raddr;
    logic [3:0] g_rptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rlevel;
    logic       underflow;

    always #5 rclk = ~rclk;

    rptr_ctrl #(
        .ADDR_W    (ADDR_W),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .r_en         (r_en),
        .g_wptr_sync  (g_wptr_sync),
        .r_fire       (r_fire),
        .raddr        (raddr),
        .g_rptr       (g_rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel),
        .underflow    (underflow)
    );

    typedef struct packed {
        logic       empty;
        logic       aempty;
        logic [3:0] rlevel;
        logic [3:0] g_rptr;
        logic [2:0] raddr;
        logic       uf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: read count, expected empty, expected underflow.
    int   m_rd = 0;
    logic m_empty = 1'b1;
    logic m_uf = 1'b0;
    int   wr = 0;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"},  32'(empty),        32'd1);
        check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        check({tag, "_rlevel"}, 32'(rlevel),       32'd0);
        check({tag, "_g_rptr"}, 32'(g_rptr),       32'd0);
        check({tag, "_raddr"},  32'(raddr),        32'd0);
        check({tag, "_uf"},     32'(underflow),    32'd0);
        check({tag, "_r_fire"}, 32'(r_fire),       32'd0);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            check("empty",        32'(empty),        32'(e.empty));
            check("almost_empty", 32'(almost_empty), 32'(e.aempty));
            check("rlevel",       32'(rlevel),       32'(e.rlevel));
            check("g_rptr",       32'(g_rptr),       32'(e.g_rptr));
            check("raddr",        32'(raddr),        32'(e.raddr));
            check("underflow",    32'(underflow),    32'(e.uf));
        end
    endtask

    // One rclk cycle: drive inputs at the falling edge, check r_fire, then the registered outputs.
    task automatic step(input logic ren, input int wr_cnt);
        exp_t       e;
        int         fire;
        int         rd_n;
        int         lvl;
        logic [3:0] prev_g;
        @(negedge rclk);
        r_en        = ren;
        g_wptr_sync = gray4(wr_cnt);
        fire        = (ren && !m_empty) ? 1 : 0;
        #1;
        check("r_fire", 32'(r_fire), 32'(fire));
        rd_n = (m_rd + fire) % 16;
        lvl  = ((wr_cnt % 16) - rd_n + 16) % 16;
`ifdef RPTR_UNDERFLOW_DET_EN
        if (ren && m_empty) m_uf = 1'b1;
`endif
        m_rd     = rd_n;
        m_empty  = (lvl == 0);
        e.empty  = m_empty;
        e.aempty = (lvl <= AEMPTY_TH);
        e.rlevel = 4'(lvl);
        e.g_rptr = gray4(rd_n);
        e.raddr  = 3'(rd_n % 8);
        e.uf     = m_uf;
        sb.push_back(e);
        prev_g = g_rptr;
        @(posedge rclk);
        #1;
        compare_out();
        if (fire == 1) begin
            check("g_rptr_one_bit", 32'($countones(g_rptr ^ prev_g)), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        // Power-on reset.
        rrst_n      = 1'b0;
        r_en        = 1'b0;
        g_wptr_sync = 4'd0;
        #12;
        check_reset("por");
        @(negedge rclk);
        rrst_n = 1'b1;

        step(1'b0, 0);

        // Three entries written, then read out one per cycle.
        wr = 3;
        step(1'b0, wr);
        step(1'b1, wr);
        step(1'b1, wr);
        step(1'b1, wr);

        // Read while empty: ignored, optionally flagged, flag is sticky.
        step(1'b1, wr);
        step(1'b0, wr);
        step(1'b0, wr);

        // Asynchronous reset in the middle of a read request.
        @(negedge rclk);
        g_wptr_sync = 4'd0;
        r_en        = 1'b1;
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset("mid");
        m_rd    = 0;
        m_empty = 1'b1;
        m_uf    = 1'b0;
        wr      = 0;
        @(negedge rclk);
        r_en   = 1'b0;
        rrst_n = 1'b1;

        // Full FIFO from pointer 0.
        wr = 8;
        step(1'b0, wr);

        // Twenty write/read pairs: read pointer wraps through 15 -> 0.
        for (int i = 0; i < 20; i++) begin
            wr++;
            step(1'b1, wr);
        end

        // Drain down to one entry.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, wr);
        end

        // Write arriving in the same cycle as the last read keeps one entry.
        wr++;
        step(1'b1, wr);
        step(1'b1, wr);
        step(1'b0, wr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
